branch_target_buffer: RTL and testbench
=======================================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 Parameter ENTRIES, default 8: number of fully associative entries; power of two, 2..64.
REQ-002 Parameter ADDR_W, default 32: PC and target width.
REQ-003 Parameter CTR_W, default 2: saturating predictor counter width, 2..4.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 lookup_pc  input  ADDR_W  PC of the instruction being fetched.
REQ-007 hit  output  1  lookup_pc matches a valid entry.
REQ-008 pred_taken  output  1  hit AND counter MSB set.
REQ-009 pred_target  output  ADDR_W  stored target of the matching entry; 0 when no hit.
REQ-010 hit_index  output  $clog2(ENTRIES)  index of the matching entry; 0 when no hit.
REQ-011 upd_valid  input  1  resolved-branch update strobe from decode.
REQ-012 upd_pc  input  ADDR_W  PC of the resolved branch.
REQ-013 upd_taken  input  1  actual branch outcome.
REQ-014 upd_target  input  ADDR_W  actual branch target.
REQ-015 flush  input  1  invalidate all entries.
REQ-016 occupancy  output  $clog2(ENTRIES)+1  count of valid entries.

Function
REQ-017 Lookup is combinational, zero latency: at most one entry matches, because allocation never duplicates a PC.
REQ-018 Lookup reflects state as of the last clock edge; there is no bypass of a same-cycle update.
REQ-019 Update when upd_pc hits: counter +1 on taken, -1 on not-taken, saturating at 0 and 2^CTR_W-1; target overwritten only when taken.
REQ-020 Update when upd_pc misses and upd_taken=1: allocate, set valid, store PC and target, set counter to weakly-taken (MSB=1, rest 0).
REQ-021 Update when upd_pc misses and upd_taken=0: no state change.
REQ-022 Victim selection: lowest-index invalid entry; if all are valid, the entry at round-robin pointer rr_ptr.
REQ-023 rr_ptr advances by 1, modulo ENTRIES, only on an allocation that evicts a valid entry.
REQ-024 Flush: all valid bits cleared and rr_ptr set to 0 at the next edge; flush overrides a simultaneous upd_valid, which is dropped.
REQ-025 Update-path matching is independent of lookup-path matching; both run every cycle.
REQ-026 occupancy updates on the same edge as the valid bits; it saturates naturally at ENTRIES.
REQ-027 Updates are single-cycle, with no back-pressure; one update accepted per cycle.

Reset
REQ-028 While rst_n=0: all valid bits=0, rr_ptr=0, counters=0, tags and targets=0; outputs hit=0, pred_taken=0, pred_target=0, hit_index=0, occupancy=0.
REQ-029 Reset asserted mid-update discards the update; operation resumes on the first edge after rst_n rises.

Structure
REQ-030 Shared package bp_pkg holds the counter-encoding constants (WEAK_TAKEN, STRONG_TAKEN, WEAK_NT, STRONG_NT for CTR_W=2) and a typedef for the entry record {valid, tag, target, ctr}.
REQ-031 One sub-module, sat_counter (CTR_W parameter; inc, dec, load, load_val inputs), instantiated per entry.
REQ-032 No memory macros; the entry array is flops, so a single-cycle flush is possible.

Verification
REQ-033 Reset, then lookup 0x100 -> hit=0, pred_target=0, occupancy=0.
REQ-034 Update pc=0x100, taken, target=0x200; next cycle lookup 0x100 -> hit=1, pred_taken=1, pred_target=0x200, hit_index=0, occupancy=1.
REQ-035 Three not-taken updates to 0x100 -> counter 10->01->00->00 (saturates); pred_taken=0, and lookup still hits.
REQ-036 ENTRIES=8: allocate 8 taken PCs 0x0..0x1C, then a 9th at 0x40 -> entry 0 evicted, 0x0 misses, 0x40 hits at index 0; a 10th PC replaces index 1.
REQ-037 Same cycle: flush=1 and upd_valid (taken, 0x300) -> next cycle occupancy=0 and 0x300 misses.
REQ-038 Same cycle: lookup and update to new PC 0x500 -> hit=0 that cycle, hit=1 next cycle; rst_n pulsed low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared branch-predictor definitions. Holds the counter
//                encodings, the entry record type and a helper that builds
//                the weakly-taken value for any counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

  // Widest supported fields; narrower instances use the low bits.
  localparam int CTR_MAX_W  = 4;
  localparam int ADDR_MAX_W = 64;

  // Two-bit counter encodings. MSB set means "predict taken".
  localparam logic [1:0] STRONG_NT    = 2'b00;
  localparam logic [1:0] WEAK_NT      = 2'b01;
  localparam logic [1:0] WEAK_TAKEN   = 2'b10;
  localparam logic [1:0] STRONG_TAKEN = 2'b11;

  // One BTB entry as a record.
  typedef struct packed {
    logic                  valid;
    logic [ADDR_MAX_W-1:0] tag;
    logic [ADDR_MAX_W-1:0] target;
    logic [CTR_MAX_W-1:0]  ctr;
  } bp_entry_t;

  // Weakly-taken for a w-bit counter: MSB set, all other bits clear.
  function automatic logic [CTR_MAX_W-1:0] ctr_weak_taken(input int unsigned w);
    return CTR_MAX_W'(1) << (w - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up/down counter with synchronous load. Load has
//                priority over inc/dec; the count sticks at 0 and all-ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  output logic [CTR_W-1:0] value
);

  localparam logic [CTR_W-1:0] c_max = '1;

  logic [CTR_W-1:0] r_value;

  // Counter register: load, else saturating increment/decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (load) begin
      r_value <= load_val;
    end else if (inc && (r_value != c_max)) begin
      r_value <= r_value + CTR_W'(1);
    end else if (dec && (r_value != '0)) begin
      r_value <= r_value - CTR_W'(1);
    end
  end

  assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target_buffer
//  Description : Fully associative BTB with per-entry saturating direction
//                counters. Combinational lookup, single-cycle update,
//                lowest-free / round-robin replacement, single-cycle flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_target_buffer
  import bp_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int ADDR_W  = 32,
  parameter int CTR_W   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          lookup_pc,
  output logic                       hit,
  output logic                       pred_taken,
  output logic [ADDR_W-1:0]          pred_target,
  output logic [$clog2(ENTRIES)-1:0] hit_index,
  input  logic                       upd_valid,
  input  logic [ADDR_W-1:0]          upd_pc,
  input  logic                       upd_taken,
  input  logic [ADDR_W-1:0]          upd_target,
  input  logic                       flush,
  output logic [$clog2(ENTRIES):0]   occupancy
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_MAX_W-1:0] c_weak_taken_full = ctr_weak_taken(CTR_W);
  localparam logic [CTR_W-1:0]     c_weak_taken      = c_weak_taken_full[CTR_W-1:0];

  logic [ENTRIES-1:0] r_valid;
  logic [ADDR_W-1:0]  r_tag    [ENTRIES];
  logic [ADDR_W-1:0]  r_target [ENTRIES];
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [CTR_W-1:0]   w_ctr    [ENTRIES];

  logic               w_lk_msb;
  logic               w_up_hit;
  logic [IDX_W-1:0]   w_up_idx;
  logic               w_any_free;
  logic [IDX_W-1:0]   w_free_idx;
  logic [IDX_W-1:0]   w_victim;
  logic               w_upd_ok;
  logic               w_alloc;

  // Lookup match: allocation never duplicates a tag, so at most one entry hits.
  always_comb begin
    hit         = 1'b0;
    pred_target = '0;
    hit_index   = '0;
    w_lk_msb    = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (r_valid[i] && (r_tag[i] == lookup_pc)) begin
        hit         = 1'b1;
        pred_target = r_target[i];
        hit_index   = IDX_W'(i);
        w_lk_msb    = w_ctr[i][CTR_W-1];
      end
    end
  end

  assign pred_taken = hit & w_lk_msb;

  // Update-side match and lowest-index free entry search.
  always_comb begin
    w_up_hit   = 1'b0;
    w_up_idx   = '0;
    w_any_free = 1'b0;
    w_free_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (r_valid[i] && (r_tag[i] == upd_pc)) begin
        w_up_hit = 1'b1;
        w_up_idx = IDX_W'(i);
      end
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_any_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  // Flush swallows any concurrent update.
  assign w_upd_ok = upd_valid & ~flush;
  assign w_alloc  = w_upd_ok & ~w_up_hit & upd_taken;
  assign w_victim = w_any_free ? w_free_idx : r_rr_ptr;

  // Entry valid/tag/target storage and replacement pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= '0;
      r_rr_ptr <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
      end
    end else if (flush) begin
      r_valid  <= '0;
      r_rr_ptr <= '0;
    end else if (w_upd_ok) begin
      if (w_up_hit && upd_taken) begin
        r_target[w_up_idx] <= upd_target;
      end
      if (w_alloc) begin
        r_valid[w_victim]  <= 1'b1;
        r_tag[w_victim]    <= upd_pc;
        r_target[w_victim] <= upd_target;
        if (!w_any_free) begin
          r_rr_ptr <= r_rr_ptr + IDX_W'(1);
        end
      end
    end
  end

  // Per-entry direction counters.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    logic w_sel_hit;
    assign w_sel_hit = w_upd_ok & w_up_hit & (w_up_idx == IDX_W'(g));

    sat_counter #(
      .CTR_W (CTR_W)
    ) u_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (w_sel_hit & upd_taken),
      .dec      (w_sel_hit & ~upd_taken),
      .load     (w_alloc & (w_victim == IDX_W'(g))),
      .load_val (c_weak_taken),
      .value    (w_ctr[g])
    );
  end

  // Occupancy is a population count of the registered valid bits.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      occupancy = occupancy + (IDX_W + 1)'(r_valid[i]);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_target_buffer
//  Description : Self-checking bench for branch_target_buffer (default
//                parameters) with directed scenarios and random traffic
//                compared against an array-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_buffer;

  localparam int N  = 8;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] lookup_pc = '0;
  logic          hit;
  logic          pred_taken;
  logic [AW-1:0] pred_target;
  logic [2:0]    hit_index;
  logic          upd_valid = 1'b0;
  logic [AW-1:0] upd_pc = '0;
  logic          upd_taken = 1'b0;
  logic [AW-1:0] upd_target = '0;
  logic          flush = 1'b0;
  logic [3:0]    occupancy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain arrays indexed by entry slot.
  bit          m_valid  [N];
  int unsigned m_tag    [N];
  int unsigned m_target [N];
  int          m_ctr    [N];
  int          m_rr;

  branch_target_buffer #(.ENTRIES(N), .ADDR_W(AW), .CTR_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_pc   (lookup_pc),
    .hit         (hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .hit_index   (hit_index),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .flush       (flush),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 0;
    end
    m_rr = 0;
  endfunction

  function automatic int model_find(input int unsigned pc);
    for (int i = 0; i < N; i++)
      if (m_valid[i] && m_tag[i] == pc) return i;
    return -1;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_valid[i];
    return c;
  endfunction

  function automatic void model_apply(input bit uv, input int unsigned pc, input bit tk,
                                      input int unsigned tg, input bit fl);
    int j;
    int v;
    if (fl) begin
      for (int i = 0; i < N; i++) m_valid[i] = 0;
      m_rr = 0;
      return;
    end
    if (!uv) return;
    j = model_find(pc);
    if (j >= 0) begin
      if (tk) begin
        m_ctr[j]    = (m_ctr[j] < 3) ? m_ctr[j] + 1 : 3;
        m_target[j] = tg;
      end else begin
        m_ctr[j] = (m_ctr[j] > 0) ? m_ctr[j] - 1 : 0;
      end
    end else if (tk) begin
      v = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) v = i;
      if (v < 0) begin
        v = m_rr;
        m_rr = (m_rr + 1) % N;
      end
      m_valid[v] = 1; m_tag[v] = pc; m_target[v] = tg; m_ctr[v] = 2;
    end
  endfunction

  // Compare combinational lookup outputs against the model's current state.
  task automatic check_model(input string tag);
    int j;
    j = model_find(lookup_pc);
    chk({tag, ".hit"},    hit,         (j >= 0));
    chk({tag, ".taken"},  pred_taken,  (j >= 0) && (m_ctr[j] >= 2));
    chk({tag, ".target"}, pred_target, (j >= 0) ? m_target[j] : 0);
    chk({tag, ".idx"},    hit_index,   (j >= 0) ? j : 0);
    chk({tag, ".occ"},    occupancy,   model_count());
  endtask

  // One clock: drive at negedge, check before the edge, then advance model.
  task automatic step(input logic [AW-1:0] lpc, input bit uv, input logic [AW-1:0] upc,
                      input bit tk, input logic [AW-1:0] tg, input bit fl);
    lookup_pc = lpc; upd_valid = uv; upd_pc = upc;
    upd_taken = tk; upd_target = tg; flush = fl;
    #1;
    check_model("step");
    @(posedge clk);
    model_apply(uv, upc, tk, tg, fl);
    @(negedge clk);
    upd_valid = 1'b0; flush = 1'b0;
  endtask

  // Directed lookup with fixed expected values.
  task automatic expect_lookup(input string tag, input logic [AW-1:0] pc, input bit e_hit,
                               input bit e_tk, input logic [AW-1:0] e_tg,
                               input int e_idx, input int e_occ);
    lookup_pc = pc; upd_valid = 1'b0; flush = 1'b0;
    #1;
    chk({tag, ".hit"},    hit,         e_hit);
    chk({tag, ".taken"},  pred_taken,  e_tk);
    chk({tag, ".target"}, pred_target, e_tg);
    chk({tag, ".idx"},    hit_index,   e_idx);
    chk({tag, ".occ"},    occupancy,   e_occ);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [AW-1:0] pc;
    model_reset();
    // Outputs during reset.
    lookup_pc = 32'h100;
    #3;
    chk("rst.hit", hit, 0);
    chk("rst.occ", occupancy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    expect_lookup("empty", 32'h100, 0, 0, 0, 0, 0);

    step(32'h0, 1, 32'h100, 1, 32'h200, 0);
    expect_lookup("alloc", 32'h100, 1, 1, 32'h200, 0, 1);

    for (int k = 0; k < 3; k++) step(32'h100, 1, 32'h100, 0, 32'h0, 0);
    expect_lookup("sat_nt", 32'h100, 1, 0, 32'h200, 0, 1);

    step(32'h0, 0, 32'h0, 0, 32'h0, 1);
    expect_lookup("flush", 32'h100, 0, 0, 0, 0, 0);

    for (int k = 0; k < 8; k++) step(32'h0, 1, AW'(k * 4), 1, AW'(32'h1000 + k), 0);
    expect_lookup("full", 32'h1C, 1, 1, 32'h1007, 7, 8);
    step(32'h0, 1, 32'h40, 1, 32'h2000, 0);
    expect_lookup("evict0.old", 32'h0, 0, 0, 0, 0, 8);
    expect_lookup("evict0.new", 32'h40, 1, 1, 32'h2000, 0, 8);
    step(32'h0, 1, 32'h80, 1, 32'h3000, 0);
    expect_lookup("evict1.new", 32'h80, 1, 1, 32'h3000, 1, 8);
    expect_lookup("evict1.old", 32'h4, 0, 0, 0, 0, 8);

    step(32'h300, 1, 32'h300, 1, 32'h3300, 1);
    expect_lookup("flush_upd", 32'h300, 0, 0, 0, 0, 0);

    step(32'h500, 1, 32'h500, 1, 32'h600, 0);
    expect_lookup("no_bypass", 32'h500, 1, 1, 32'h600, 0, 1);

    // Random traffic over a small PC pool so hits, evictions and saturation occur.
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == 200) begin
        lookup_pc = 32'h500; upd_valid = 1'b1; upd_pc = 32'h700;
        upd_taken = 1'b1; upd_target = 32'h777;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.hit",    hit,         0);
        chk("midrst.taken",  pred_taken,  0);
        chk("midrst.target", pred_target, 0);
        chk("midrst.idx",    hit_index,   0);
        chk("midrst.occ",    occupancy,   0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0;
        rst_n = 1'b1;
        expect_lookup("postrst", 32'h700, 0, 0, 0, 0, 0);
      end
      pc = AW'($urandom_range(0, 11) * 4 + 32'h8000);
      step(AW'($urandom_range(0, 11) * 4 + 32'h8000),
           ($urandom_range(0, 9) < 6), pc, ($urandom_range(0, 9) < 6),
           AW'($urandom), ($urandom_range(0, 99) < 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
